// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON input-packet front end: FSM states,
// info-byte bit positions and the fixed packet header layout.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        KEYLD,
        BLK_LO,
        BLK_HI
    } state_t;

    localparam int unsigned INFO_DIR  = 4;
    localparam int unsigned INFO_KEY  = 5;
    localparam int unsigned INFO_LAST = 6;
    localparam int unsigned INFO_2BLK = 7;

    // Header bytes sit above the N-dependent payload in every packet.
    typedef struct packed {
        logic [7:0] info;
        logic [7:0] count;
    } pkt_hdr_t;

endpackage

// File: rtl/simon_data_in.sv
// Input-packet front end: captures host packets, validates mode/sequence/direction,
// then loads the key register or hands one or two blocks to the cipher core.
module simon_data_in
    import simon_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 4,
    parameter int unsigned MODE = 0
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic [8*(2+N/2)-1:0]   in,
    input  logic                   doneIN,
    output logic                   readIN,
    output logic [2*N-1:0]         blockIN,
    output logic [7:0]             infoIN,
    output logic [7:0]             countIN,
    output logic                   doneData,
    input  logic                   readData,
    output logic [M*N-1:0]         KEY,
    output logic                   keyValid,
    output logic                   errCount,
    output logic                   errMode,
    output logic                   errDir
);

    typedef struct packed {
        pkt_hdr_t             hdr;
        logic [3:0][N-1:0]    data;
    } pkt_t;

    state_t                state;
    pkt_t                  pkt;
    logic [7:0]            expected;
    logic [M-1:0][N-1:0]   key;

    assign KEY = key;

    always_ff @(posedge clk) begin
        if (R) begin
            state    <= IDLE;
            pkt      <= '0;
            expected <= '0;
            key      <= '0;
            readIN   <= 1'b0;
            keyValid <= 1'b0;
            doneData <= 1'b0;
            blockIN  <= '0;
            infoIN   <= '0;
            countIN  <= '0;
            errCount <= 1'b0;
            errMode  <= 1'b0;
            errDir   <= 1'b0;
        end else begin
            readIN   <= 1'b0;
            keyValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (doneIN && !readIN) begin
                        pkt    <= in;
                        readIN <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (pkt.hdr.count != expected) begin
                        errCount <= 1'b1;
                        state    <= IDLE;
                    end else if (pkt.hdr.info[3:0] != MODE[3:0]) begin
                        errMode <= 1'b1;
                        state   <= IDLE;
                    end else if (pkt.hdr.info[INFO_DIR]) begin
                        errDir <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        expected <= pkt.hdr.info[INFO_LAST] ? 8'd0 : expected + 8'd1;
                        state    <= pkt.hdr.info[INFO_KEY] ? KEYLD : BLK_LO;
                    end
                end
                KEYLD: begin
                    for (int unsigned i = 0; i < M; i++) begin
                        key[i] <= pkt.data[i];
                    end
                    keyValid <= 1'b1;
                    state    <= IDLE;
                end
                BLK_LO, BLK_HI: begin
                    // Each half spends one cycle with doneData low before presenting.
                    if (!doneData) begin
                        doneData <= 1'b1;
                        blockIN  <= (state == BLK_LO) ? {pkt.data[1], pkt.data[0]}
                                                      : {pkt.data[3], pkt.data[2]};
                        infoIN   <= pkt.hdr.info;
                        countIN  <= pkt.hdr.count;
                    end else if (readData) begin
                        doneData <= 1'b0;
                        state    <= (state == BLK_LO && pkt.hdr.info[INFO_2BLK]) ? BLK_HI : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_data_in.sv
// Randomised bench for simon_data_in: a transaction-level host/core driver that
// schedules expected outputs per cycle, checked by one negedge compare process.
module tb_simon_data_in;

    localparam int unsigned N = 16;
    localparam int unsigned M = 4;
    localparam int unsigned W = 8 * (2 + N / 2);

    logic             clk = 1'b0;
    logic             R;
    logic [W-1:0]     in_pkt;
    logic             doneIN;
    logic             readIN;
    logic [2*N-1:0]   blockIN;
    logic [7:0]       infoIN;
    logic [7:0]       countIN;
    logic             doneData;
    logic             readData;
    logic [M*N-1:0]   KEY;
    logic             keyValid;
    logic             errCount;
    logic             errMode;
    logic             errDir;

    simon_data_in #(.N(N), .M(M), .MODE(0)) dut (
        .clk      (clk),
        .R        (R),
        .in       (in_pkt),
        .doneIN   (doneIN),
        .readIN   (readIN),
        .blockIN  (blockIN),
        .infoIN   (infoIN),
        .countIN  (countIN),
        .doneData (doneData),
        .readData (readData),
        .KEY      (KEY),
        .keyValid (keyValid),
        .errCount (errCount),
        .errMode  (errMode),
        .errDir   (errDir)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected outputs for the current cycle, plus the model's sequence counter.
    logic             check_en = 1'b0;
    logic             exp_readIN, exp_keyValid, exp_doneData;
    logic [2*N-1:0]   exp_block;
    logic [7:0]       exp_info, exp_count;
    logic [M*N-1:0]   exp_key;
    logic             exp_errC, exp_errM, exp_errD;
    logic [7:0]       model_expected;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("readIN",   readIN,   exp_readIN);
            chk("keyValid", keyValid, exp_keyValid);
            chk("doneData", doneData, exp_doneData);
            chk("blockIN",  blockIN,  exp_block);
            chk("infoIN",   infoIN,   exp_info);
            chk("countIN",  countIN,  exp_count);
            chk("KEY",      KEY,      exp_key);
            chk("errCount", errCount, exp_errC);
            chk("errMode",  errMode,  exp_errM);
            chk("errDir",   errDir,   exp_errD);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_readIN   = 1'b0;
        exp_keyValid = 1'b0;
    endtask

    task automatic do_reset();
        R        = 1'b1;
        doneIN   = 1'b0;
        readData = 1'b0;
        step();
        R              = 1'b0;
        exp_doneData   = 1'b0;
        exp_block      = '0;
        exp_info       = '0;
        exp_count      = '0;
        exp_key        = '0;
        exp_errC       = 1'b0;
        exp_errM       = 1'b0;
        exp_errD       = 1'b0;
        model_expected = '0;
    endtask

    // 0 = accepted, 1 = bad count, 2 = bad mode, 3 = wrong direction
    function automatic int classify(input logic [7:0] info, input logic [7:0] count);
        if (count != model_expected) return 1;
        if (info[3:0] != 4'd0)       return 2;
        if (info[4])                 return 3;
        return 0;
    endfunction

    task automatic deliver(input logic [2*N-1:0] blk, input logic [7:0] info,
                           input logic [7:0] count, input int hold, input bit abort);
        int h;
        step();
        exp_doneData = 1'b1;
        exp_block    = blk;
        exp_info     = info;
        exp_count    = count;
        readData     = 1'b0;
        h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        repeat (h) step();
        if (abort) begin
            do_reset();
            return;
        end
        readData = 1'b1;
        step();
        exp_doneData = 1'b0;
        readData     = 1'($urandom_range(0, 1));
    endtask

    // Called in a cycle where the DUT is idle; returns in the first idle cycle after.
    task automatic send_pkt(input logic [7:0] info, input logic [7:0] count,
                            input logic [3:0][N-1:0] data, input int hold_lo,
                            input int hold_hi, input bit abort_hi);
        int r;
        doneIN = 1'b1;
        in_pkt = {info, count, data};
        step();
        exp_readIN = 1'b1;
        doneIN     = 1'b0;
        readData   = 1'($urandom_range(0, 1));
        step();
        r = classify(info, count);
        readData = 1'($urandom_range(0, 1));
        if (r == 1) begin exp_errC = 1'b1; return; end
        if (r == 2) begin exp_errM = 1'b1; return; end
        if (r == 3) begin exp_errD = 1'b1; return; end
        model_expected = info[6] ? 8'd0 : model_expected + 8'd1;
        if (info[5]) begin
            step();
            exp_keyValid = 1'b1;
            exp_key      = data[M-1:0];
            readData     = 1'b0;
            return;
        end
        deliver({data[1], data[0]}, info, count, hold_lo, 1'b0);
        if (info[7]) deliver({data[3], data[2]}, info, count, hold_hi, abort_hi);
    endtask

    function automatic logic [3:0][N-1:0] rnd_data();
        logic [3:0][N-1:0] d;
        for (int i = 0; i < 4; i++) d[i] = N'($urandom);
        return d;
    endfunction

    initial begin
        logic [3:0][N-1:0] d;
        logic [7:0] info;
        logic [7:0] cnt;

        R = 1'b1; doneIN = 1'b0; readData = 1'b0; in_pkt = '0;
        exp_readIN = 1'b0; exp_keyValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_en = 1'b1;

        // Key load
        d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        send_pkt(8'h20, 8'd0, d, 0, 0, 1'b0);
        chk("key_lit", KEY, 64'h4444_3333_2222_1111);
        chk("key_pulse_lit", keyValid, 1'b1);

        // Single block held for five cycles
        d = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        send_pkt(8'h00, 8'd1, d, 5, 0, 1'b0);
        chk("blk_lo_lit", blockIN, 32'hBBBB_AAAA);

        // Two-block packet
        d = {16'h0303, 16'h0202, 16'h0101, 16'h0000};
        send_pkt(8'h80, 8'd2, d, -1, -1, 1'b0);
        chk("blk_hi_lit", blockIN, 32'h0303_0202);
        chk("count_lit", countIN, 8'd2);

        // Error cases; expected count stays 3
        send_pkt(8'h00, 8'd7, rnd_data(), 0, 0, 1'b0);
        chk("errcount_lit", errCount, 1'b1);
        send_pkt(8'h01, 8'd3, rnd_data(), 0, 0, 1'b0);
        chk("errmode_lit", errMode, 1'b1);
        send_pkt(8'h10, 8'd3, rnd_data(), 0, 0, 1'b0);
        chk("errdir_lit", errDir, 1'b1);
        send_pkt(8'h00, 8'd3, rnd_data(), 0, 0, 1'b0);
        chk("seq3_lit", countIN, 8'd3);

        // Last packet at count 255 resets the sequence
        do_reset();
        for (int i = 0; i < 255; i++) begin
            info = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h20;
            send_pkt(info, 8'(i), rnd_data(), 0, 0, 1'b0);
        end
        send_pkt(8'h40, 8'd255, rnd_data(), 0, 0, 1'b0);
        chk("last255_cnt_lit", countIN, 8'd255);
        send_pkt(8'h20, 8'd0, rnd_data(), 0, 0, 1'b0);
        chk("after_last_lit", errCount, 1'b0);

        // Natural 8-bit wrap without a last packet
        do_reset();
        for (int i = 0; i < 256; i++) send_pkt(8'h20, 8'(i), rnd_data(), 0, 0, 1'b0);
        send_pkt(8'h20, 8'd0, rnd_data(), 0, 0, 1'b0);
        chk("wrap_lit", errCount, 1'b0);

        // Reset while the second block is pending
        send_pkt(8'h80, 8'd1, rnd_data(), 0, 1, 1'b1);
        chk("rst_done_lit", doneData, 1'b0);
        chk("rst_blk_lit", blockIN, 32'h0);
        send_pkt(8'h20, 8'd0, rnd_data(), 0, 0, 1'b0);
        chk("rst_accept_lit", errCount, 1'b0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            info[3:0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            info[4]   = ($urandom_range(0, 7) == 0);
            info[5]   = ($urandom_range(0, 2) == 0);
            info[6]   = ($urandom_range(0, 9) == 0);
            info[7]   = 1'($urandom_range(0, 1));
            cnt = ($urandom_range(0, 5) == 0) ? 8'($urandom) : model_expected;
            send_pkt(info, cnt, rnd_data(), -1, -1, 1'b0);
            if ($urandom_range(0, 3) == 0) step();
        end
        step();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
